// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: opcodes, opcode classes, sequencer states and
// ALU function codes. Also used by the ALU and the register encode stage.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_BITS = 5;

  // Opcode constants (IR[31:27])
  localparam logic [OPC_BITS-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_BITS-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_BITS-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_BITS-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_BITS-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_BITS-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_BITS-1:0] OP_HALT = 5'b11011;

  // ALU function codes
  localparam logic [OPC_BITS-1:0] ALU_ADD = 5'b00011;
  localparam logic [OPC_BITS-1:0] ALU_AND = 5'b00101;
  localparam logic [OPC_BITS-1:0] ALU_OR  = 5'b00110;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_LD,
    CLS_LDI,
    CLS_ST,
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_HALT
  } op_class_e;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALTED
  } state_e;

  // ALU code used in T4 by the immediate-operand classes
  function automatic logic [OPC_BITS-1:0] imm_alu_code(input logic [OPC_BITS-1:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode -> opcode class decode.
// Ports: i_op_code (IR[31:27]), o_class_c (decoded class; unknown codes -> NOP).
module opcode_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_BITS-1:0] i_op_code,
  output op_class_e           o_class_c
);

  always_comb begin
    o_class_c = CLS_NOP;
    if (i_op_code == OP_LD) begin
      o_class_c = CLS_LD;
    end else if (i_op_code == OP_LDI) begin
      o_class_c = CLS_LDI;
    end else if (i_op_code == OP_ST) begin
      o_class_c = CLS_ST;
    end else if ((i_op_code >= OP_ADD) && (i_op_code <= OP_SHL)) begin
      o_class_c = CLS_ALU_R;
    end else if ((i_op_code >= OP_ADDI) && (i_op_code <= OP_ORI)) begin
      o_class_c = CLS_ALU_I;
    end else if (i_op_code == OP_HALT) begin
      o_class_c = CLS_HALT;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute T-step sequencer for the reduced ISA.
// Ports: clk, rst_n (sync, active-low); op_code from the encode stage;
// mem_ready memory completion; gra/grb/grc/rin/rout/baout to the encode stage;
// datapath strobes pc_out..c_out; alu_op; mem_rd/mem_wr; run; instr_count.
// Outputs are Moore decodes of the state (plus op_code/mem_ready) so that
// mdr_in can accompany mem_ready in the same cycle.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] op_code,
  input  logic             mem_ready,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             rin,
  output logic             rout,
  output logic             baout,
  output logic             pc_out,
  output logic             pc_inc,
  output logic             mar_in,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             z_in,
  output logic             zlo_out,
  output logic             c_out,
  output logic [OPC_W-1:0] alu_op,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             run,
  output logic [CNT_W-1:0] instr_count
);

  state_e           r_state;
  state_e           w_next;
  op_class_e        r_class;
  op_class_e        w_class;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;

  opcode_class_decode u_decode (
    .i_op_code (OPC_BITS'(op_code)),
    .o_class_c (w_class)
  );

  // State, latched class and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_RESET;
      r_class       <= CLS_NOP;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T3) begin
        r_class <= w_class;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign instr_count = r_instr_count;

  // Next-state; T3 branches on the live decode, later steps on the latched class
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = mem_ready ? S_T2 : S_T1;
      S_T2:    w_next = S_T3;
      S_T3: begin
        if (w_class == CLS_NOP) begin
          w_next = S_T0;
        end else if (w_class == CLS_HALT) begin
          w_next = S_HALTED;
        end else begin
          w_next = S_T4;
        end
      end
      S_T4:    w_next = S_T5;
      S_T5:    w_next = ((r_class == CLS_LD) || (r_class == CLS_ST)) ? S_T6 : S_T0;
      S_T6: begin
        if (r_class == CLS_LD) begin
          w_next = mem_ready ? S_T7 : S_T6;
        end else begin
          w_next = S_T7;
        end
      end
      S_T7: begin
        if (r_class == CLS_ST) begin
          w_next = mem_ready ? S_T0 : S_T7;
        end else begin
          w_next = S_T0;
        end
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_RESET;
    endcase
  end

  // An instruction retires when execute returns to T0 or enters HALTED
  always_comb begin
    w_retire = 1'b0;
    if ((w_next == S_T0) &&
        ((r_state == S_T3) || (r_state == S_T5) || (r_state == S_T7))) begin
      w_retire = 1'b1;
    end
    if ((w_next == S_HALTED) && (r_state == S_T3)) begin
      w_retire = 1'b1;
    end
  end

  // Strobe decode
  always_comb begin
    gra     = 1'b0;
    grb     = 1'b0;
    grc     = 1'b0;
    rin     = 1'b0;
    rout    = 1'b0;
    baout   = 1'b0;
    pc_out  = 1'b0;
    pc_inc  = 1'b0;
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    mdr_out = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    c_out   = 1'b0;
    alu_op  = '0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    run     = (r_state != S_RESET) && (r_state != S_HALTED);
    unique case (r_state)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        pc_inc = 1'b1;
      end
      S_T1: begin
        mem_rd = 1'b1;
        mdr_in = mem_ready;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (w_class == CLS_ALU_R) begin
          grb  = 1'b1;
          rout = 1'b1;
          y_in = 1'b1;
        end else if ((w_class != CLS_NOP) && (w_class != CLS_HALT)) begin
          grb   = 1'b1;
          baout = 1'b1;
          y_in  = 1'b1;
        end
      end
      S_T4: begin
        z_in = 1'b1;
        if (r_class == CLS_ALU_R) begin
          grc    = 1'b1;
          rout   = 1'b1;
          alu_op = op_code;
        end else begin
          c_out = 1'b1;
          if (r_class == CLS_ALU_I) begin
            alu_op = OPC_W'(imm_alu_code(OPC_BITS'(op_code)));
          end else begin
            alu_op = OPC_W'(ALU_ADD);
          end
        end
      end
      S_T5: begin
        zlo_out = 1'b1;
        if ((r_class == CLS_LD) || (r_class == CLS_ST)) begin
          mar_in = 1'b1;
        end else begin
          gra = 1'b1;
          rin = 1'b1;
        end
      end
      S_T6: begin
        if (r_class == CLS_LD) begin
          mem_rd = 1'b1;
          mdr_in = mem_ready;
        end else begin
          gra    = 1'b1;
          rout   = 1'b1;
          mdr_in = 1'b1;
        end
      end
      S_T7: begin
        if (r_class == CLS_LD) begin
          mdr_out = 1'b1;
          gra     = 1'b1;
          rin     = 1'b1;
        end else begin
          mem_wr = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned CNT_W = 32;

  // Strobe vector bit positions: {gra,grb,grc,rin,rout,baout,pc_out,pc_inc,
  // mar_in,mdr_in,mdr_out,ir_in,y_in,z_in,zlo_out,c_out,mem_rd,mem_wr,run}
  localparam logic [18:0] GRA  = 19'(1) << 18;
  localparam logic [18:0] GRB  = 19'(1) << 17;
  localparam logic [18:0] GRC  = 19'(1) << 16;
  localparam logic [18:0] RIN  = 19'(1) << 15;
  localparam logic [18:0] ROUT = 19'(1) << 14;
  localparam logic [18:0] BAO  = 19'(1) << 13;
  localparam logic [18:0] PCO  = 19'(1) << 12;
  localparam logic [18:0] PCI  = 19'(1) << 11;
  localparam logic [18:0] MARI = 19'(1) << 10;
  localparam logic [18:0] MDRI = 19'(1) << 9;
  localparam logic [18:0] MDRO = 19'(1) << 8;
  localparam logic [18:0] IRI  = 19'(1) << 7;
  localparam logic [18:0] YIN  = 19'(1) << 6;
  localparam logic [18:0] ZIN  = 19'(1) << 5;
  localparam logic [18:0] ZLO  = 19'(1) << 4;
  localparam logic [18:0] COUT = 19'(1) << 3;
  localparam logic [18:0] RD   = 19'(1) << 2;
  localparam logic [18:0] WR   = 19'(1) << 1;
  localparam logic [18:0] RUN  = 19'(1);
  localparam logic [18:0] NONE = 19'(0);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [OPC_W-1:0] op_code;
  logic             mem_ready;
  logic             gra, grb, grc, rin, rout, baout;
  logic             pc_out, pc_inc, mar_in, mdr_in, mdr_out, ir_in;
  logic             y_in, z_in, zlo_out, c_out;
  logic [OPC_W-1:0] alu_op;
  logic             mem_rd, mem_wr, run;
  logic [CNT_W-1:0] instr_count;

  logic [18:0]      obs;
  int               n_checks;
  int               n_errors;
  logic             mon_en;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  control_sequencer #(.OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_code     (op_code),
    .mem_ready   (mem_ready),
    .gra         (gra),
    .grb         (grb),
    .grc         (grc),
    .rin         (rin),
    .rout        (rout),
    .baout       (baout),
    .pc_out      (pc_out),
    .pc_inc      (pc_inc),
    .mar_in      (mar_in),
    .mdr_in      (mdr_in),
    .mdr_out     (mdr_out),
    .ir_in       (ir_in),
    .y_in        (y_in),
    .z_in        (z_in),
    .zlo_out     (zlo_out),
    .c_out       (c_out),
    .alu_op      (alu_op),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .run         (run),
    .instr_count (instr_count)
  );

  assign obs = {gra, grb, grc, rin, rout, baout, pc_out, pc_inc, mar_in, mdr_in,
                mdr_out, ir_in, y_in, z_in, zlo_out, c_out, mem_rd, mem_wr, run};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: apply mem_ready, check outputs at the falling edge, advance
  task automatic step(input string tag, input logic [18:0] exp_s,
                      input logic [OPC_W-1:0] exp_alu, input logic ready);
    mem_ready = ready;
    @(negedge clk);
    chk(tag, 32'(obs), 32'(exp_s));
    chk({tag, "_alu"}, 32'(alu_op), 32'(exp_alu));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, instr_count, exp_cnt);
  endtask

  // T0..T2 with `waits` not-ready cycles in T1
  task automatic fetch(input logic [OPC_W-1:0] op, input int waits);
    step("t0", PCO | MARI | PCI | RUN, '0, 1'b1);
    for (int i = 0; i < waits; i++) step("t1_wait", RD | RUN, '0, 1'b0);
    step("t1_ready", RD | MDRI | RUN, '0, 1'b1);
    op_code = op;
    step("t2", MDRO | IRI | RUN, '0, 1'b0);
  endtask

  // Register-select, register read/write and memory request exclusivity
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_gr_onehot", 32'($countones({gra, grb, grc}) <= 1), 32'(1));
      chk("inv_rin_rout", 32'(rin & rout), 32'(0));
      chk("inv_rd_wr", 32'(mem_rd & mem_wr), 32'(0));
    end
  end

  logic [OPC_W-1:0] r_ops   [3] = '{5'b00011, 5'b00111, 5'b01011};
  logic [OPC_W-1:0] i_ops   [4] = '{5'b00001, 5'b01100, 5'b01101, 5'b01110};
  logic [OPC_W-1:0] i_alus  [4] = '{5'b00011, 5'b00011, 5'b00101, 5'b00110};
  logic [OPC_W-1:0] nop_ops [3] = '{5'b11111, 5'b11010, 5'b01111};

  initial begin
    rst_n     = 1'b0;
    op_code   = '0;
    mem_ready = 1'b0;
    n_checks  = 0;
    n_errors  = 0;
    mon_en    = 1'b0;
    exp_cnt   = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset: all outputs zero, counter cleared, one RESET cycle after release
    step("reset", NONE, '0, 1'b1);
    chk_cnt("cnt_reset");
    rst_n = 1'b1;
    step("reset_release", NONE, '0, 1'b0);

    // Register-register ALU ops (first, middle, last of range)
    for (int i = 0; i < 3; i++) begin
      fetch(r_ops[i], 0);
      step("aluR_t3", GRB | ROUT | YIN | RUN, '0, 1'b0);
      step("aluR_t4", GRC | ROUT | ZIN | RUN, r_ops[i], 1'b0);
      step("aluR_t5", ZLO | GRA | RIN | RUN, '0, 1'b0);
      exp_cnt++;
      chk_cnt("cnt_aluR");
    end

    // LD with 3 wait cycles in both memory phases
    fetch(5'b00000, 3);
    step("ld_t3", GRB | BAO | YIN | RUN, '0, 1'b0);
    step("ld_t4", COUT | ZIN | RUN, 5'b00011, 1'b0);
    step("ld_t5", ZLO | MARI | RUN, '0, 1'b1);
    for (int i = 0; i < 3; i++) step("ld_t6_wait", RD | RUN, '0, 1'b0);
    step("ld_t6_ready", RD | MDRI | RUN, '0, 1'b1);
    step("ld_t7", MDRO | GRA | RIN | RUN, '0, 1'b0);
    exp_cnt++;
    chk_cnt("cnt_ld");

    // ST; mem_ready high in T6 must be ignored
    fetch(5'b00010, 0);
    step("st_t3", GRB | BAO | YIN | RUN, '0, 1'b0);
    step("st_t4", COUT | ZIN | RUN, 5'b00011, 1'b0);
    step("st_t5", ZLO | MARI | RUN, '0, 1'b0);
    step("st_t6", GRA | ROUT | MDRI | RUN, '0, 1'b1);
    step("st_t7_wait", WR | RUN, '0, 1'b0);
    step("st_t7_wait", WR | RUN, '0, 1'b0);
    step("st_t7_ready", WR | RUN, '0, 1'b1);
    exp_cnt++;
    chk_cnt("cnt_st");

    // LDI and immediate ALU ops
    for (int i = 0; i < 4; i++) begin
      fetch(i_ops[i], 0);
      step("imm_t3", GRB | BAO | YIN | RUN, '0, 1'b0);
      step("imm_t4", COUT | ZIN | RUN, i_alus[i], 1'b0);
      step("imm_t5", ZLO | GRA | RIN | RUN, '0, 1'b0);
      exp_cnt++;
      chk_cnt("cnt_imm");
    end

    // Undefined codes and NOP retire straight from T3
    for (int i = 0; i < 3; i++) begin
      fetch(nop_ops[i], 0);
      step("nop_t3", RUN, '0, 1'b1);
      exp_cnt++;
      chk_cnt("cnt_nop");
    end

    // HALT: run drops after T3 and everything stays quiet
    fetch(5'b11011, 0);
    step("halt_t3", RUN, '0, 1'b0);
    exp_cnt++;
    for (int i = 0; i < 20; i++) step("halted", NONE, '0, 1'(i % 2));
    chk_cnt("cnt_halt");
    rst_n = 1'b0;
    step("halt_reset", NONE, '0, 1'b0);
    rst_n = 1'b1;
    step("halt_reset_release", NONE, '0, 1'b0);
    exp_cnt = '0;
    chk_cnt("cnt_after_reset");

    // Reset while waiting in T1: mem_rd drops the following cycle
    step("t0", PCO | MARI | PCI | RUN, '0, 1'b0);
    step("t1_wait", RD | RUN, '0, 1'b0);
    rst_n = 1'b0;
    step("t1_wait_rst", RD | RUN, '0, 1'b0);
    rst_n = 1'b1;
    step("t1_reset", NONE, '0, 1'b0);
    step("t0_after_reset", PCO | MARI | PCI | RUN, '0, 1'b0);
    chk_cnt("cnt_t1_reset");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
